// File: rtl/m_data_memory_pkg.sv
// m_data_memory_pkg: shared constants and types for the data-port responder.
//   - MMIO register offsets within the 16-byte register window
//   - STATUS bit positions
//   - TIMER_CMP reset value
//   - helper to map an address word offset onto a register selector
package m_data_memory_pkg;

    // Byte offsets of the registers inside the MMIO window.
    localparam logic [3:0] OFF_GPIO   = 4'h0;
    localparam logic [3:0] OFF_CYCLE  = 4'h4;
    localparam logic [3:0] OFF_CMP    = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    // STATUS bit positions.
    localparam int unsigned ST_TIMER = 0;
    localparam int unsigned ST_MISAL = 1;
    localparam int unsigned ST_UNMAP = 2;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RegionRam,
        RegionMmio,
        RegionUnmapped
    } region_e;

    typedef enum logic [1:0] {
        RegGpio,
        RegCycle,
        RegCmp,
        RegStatus
    } mmio_reg_e;

    // Address bits [1:0] never take part in decode, so only the word offset is passed in.
    function automatic mmio_reg_e reg_sel(logic [1:0] word_off);
        mmio_reg_e sel;
        unique case ({word_off, 2'b00})
            OFF_GPIO:   sel = RegGpio;
            OFF_CYCLE:  sel = RegCycle;
            OFF_CMP:    sel = RegCmp;
            OFF_STATUS: sel = RegStatus;
            default:    sel = RegGpio;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/m_mmio_timer.sv
// m_mmio_timer: free-running cycle counter, timer compare register and match detect.
// Ports:
//   i_clk       clock, rising edge
//   i_reset_n   asynchronous active-low reset
//   i_cycle_we  load i_wdata into the counter this edge (replaces the increment)
//   i_cmp_we    load i_wdata into the compare register this edge
//   i_wdata     write data
//   o_cycle     current counter value
//   o_cmp       current compare value
//   o_hit       counter equals compare this cycle; the parent sets timer_hit from it
module m_mmio_timer
    import m_data_memory_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cycle_we,
    input  logic        i_cmp_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_cycle,
    output logic [31:0] o_cmp,
    output logic        o_hit
);

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] cmp_q, cmp_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        cmp_d   = cmp_q;
        if (i_cycle_we) begin
            cycle_d = i_wdata;
        end
        if (i_cmp_we) begin
            cmp_d = i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cycle_q <= 32'd0;
            cmp_q   <= CMP_RESET;
        end else begin
            cycle_q <= cycle_d;
            cmp_q   <= cmp_d;
        end
    end

    // Match uses pre-edge values, so a same-cycle CYCLE/CMP write cannot mask it.
    assign o_hit   = (cycle_q == cmp_q);
    assign o_cycle = cycle_q;
    assign o_cmp   = cmp_q;

endmodule

// File: rtl/m_data_memory.sv
// m_data_memory: responder for the core's data port.
// Word-addressed RAM at byte addresses [0, 4*DEPTH_WORDS) plus a 16-byte register
// window at MMIO_BASE: GPIO_OUT, CYCLE, TIMER_CMP, STATUS (W1C, sticky flags).
// Ports:
//   i_clk       clock, rising edge
//   i_reset_n   asynchronous active-low reset (RAM contents are not reset)
//   i_WE        write enable
//   i_address   byte address; bits [1:0] ignored for decode
//   i_data      write data
//   o_data      combinational read data for i_address
//   o_gpio      GPIO_OUT register
//   o_irq       STATUS.timer_hit
module m_data_memory
    import m_data_memory_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_WE,
    input  logic [31:0] i_address,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic [31:0] o_gpio,
    output logic        o_irq
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RamBytes = 32'(4 * DEPTH_WORDS);

    generate
        if ((DEPTH_WORDS < 4) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
            $error("DEPTH_WORDS must be a power of two and at least 4");
        end
        if ((MMIO_BASE[3:0] != 4'h0) || (MMIO_BASE < RamBytes)) begin : g_bad_base
            $error("MMIO_BASE must be 16-byte aligned and above the RAM range");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    region_e           region;
    mmio_reg_e         mmio_reg;
    logic [IdxW-1:0]   ram_idx;
    logic              misaligned;

    always_comb begin
        region = RegionUnmapped;
        if (i_address < RamBytes) begin
            region = RegionRam;
        end else if (i_address[31:4] == MMIO_BASE[31:4]) begin
            region = RegionMmio;
        end
    end

    assign mmio_reg   = reg_sel(i_address[3:2]);
    assign ram_idx    = i_address[IdxW+1:2];
    assign misaligned = (i_address[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // Write strobes
    // ------------------------------------------------------------------
    logic ram_we, gpio_we, cycle_we, cmp_we, status_we, unmap_we;

    always_comb begin
        ram_we    = 1'b0;
        gpio_we   = 1'b0;
        cycle_we  = 1'b0;
        cmp_we    = 1'b0;
        status_we = 1'b0;
        unmap_we  = 1'b0;
        if (i_WE) begin
            unique case (region)
                RegionRam:  ram_we = 1'b1;
                RegionMmio: begin
                    unique case (mmio_reg)
                        RegGpio:   gpio_we   = 1'b1;
                        RegCycle:  cycle_we  = 1'b1;
                        RegCmp:    cmp_we    = 1'b1;
                        RegStatus: status_we = 1'b1;
                        default:   ;
                    endcase
                end
                default:    unmap_we = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RAM (no reset)
    // ------------------------------------------------------------------
    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Counter / compare
    // ------------------------------------------------------------------
    logic [31:0] cycle_val, cmp_val;
    logic        timer_hit;

    m_mmio_timer u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_cycle_we (cycle_we),
        .i_cmp_we   (cmp_we),
        .i_wdata    (i_data),
        .o_cycle    (cycle_val),
        .o_cmp      (cmp_val),
        .o_hit      (timer_hit)
    );

    // ------------------------------------------------------------------
    // GPIO and STATUS
    // ------------------------------------------------------------------
    logic [31:0] gpio_q, gpio_d;
    logic [2:0]  status_q, status_d, status_set, status_clr;

    always_comb begin
        gpio_d = gpio_q;
        if (gpio_we) begin
            gpio_d = i_data;
        end

        status_set           = 3'b000;
        status_set[ST_TIMER] = timer_hit;
        status_set[ST_MISAL] = i_WE & misaligned;
        status_set[ST_UNMAP] = unmap_we;

        status_clr = status_we ? i_data[2:0] : 3'b000;
        // Set is applied after clear so it wins on a collision.
        status_d   = (status_q & ~status_clr) | status_set;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            gpio_q   <= 32'd0;
            status_q <= 3'b000;
        end else begin
            gpio_q   <= gpio_d;
            status_q <= status_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, returns pre-edge state)
    // ------------------------------------------------------------------
    always_comb begin
        o_data = 32'd0;
        unique case (region)
            RegionRam:  o_data = mem_q[ram_idx];
            RegionMmio: begin
                unique case (mmio_reg)
                    RegGpio:   o_data = gpio_q;
                    RegCycle:  o_data = cycle_val;
                    RegCmp:    o_data = cmp_val;
                    RegStatus: o_data = {29'd0, status_q};
                    default:   o_data = 32'd0;
                endcase
            end
            default:    o_data = 32'd0;
        endcase
    end

    assign o_gpio = gpio_q;
    assign o_irq  = status_q[ST_TIMER];

endmodule

// File: tb/tb_m_data_memory.sv
// Bench for m_data_memory: directed vectors with literal expectations plus a
// behavioural model of the memory map compared on every falling edge.
module tb_m_data_memory;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_WE = 1'b0;
    logic [31:0] i_address = 32'd0;
    logic [31:0] i_data = 32'd0;
    logic [31:0] o_data;
    logic [31:0] o_gpio;
    logic        o_irq;

    m_data_memory #(
        .DEPTH_WORDS (DEPTH),
        .MMIO_BASE   (BASE)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_WE      (i_WE),
        .i_address (i_address),
        .i_data    (i_data),
        .o_data    (o_data),
        .o_gpio    (o_gpio),
        .o_irq     (o_irq)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model of the memory map
    // ------------------------------------------------------------------
    bit [31:0] m_ram [DEPTH];
    bit        m_known [DEPTH];
    bit [31:0] m_gpio = 32'd0;
    bit [31:0] m_cycle = 32'd0;
    bit [31:0] m_cmp = 32'hFFFF_FFFF;
    bit [2:0]  m_status = 3'd0;

    function automatic bit is_ram(input logic [31:0] a);
        return a < 32'(4 * DEPTH);
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >> 4) == (BASE >> 4);
    endfunction

    function automatic bit model_known(input logic [31:0] a);
        if (is_ram(a)) return m_known[int'(a >> 2)];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (is_ram(a)) return m_ram[int'(a >> 2)];
        if (is_mmio(a)) begin
            case ((a >> 2) & 32'd3)
                32'd0:   return m_gpio;
                32'd1:   return m_cycle;
                32'd2:   return m_cmp;
                default: return {29'd0, m_status};
            endcase
        end
        return 32'd0;
    endfunction

    always @(negedge i_reset_n) begin
        m_gpio   = 32'd0;
        m_cycle  = 32'd0;
        m_cmp    = 32'hFFFF_FFFF;
        m_status = 3'd0;
    end

    always @(posedge i_clk) begin
        bit [2:0]  set_b;
        bit [2:0]  clr_b;
        bit [31:0] next_cycle;
        if (i_reset_n) begin
            set_b      = 3'd0;
            clr_b      = 3'd0;
            next_cycle = m_cycle + 32'd1;
            if (m_cycle == m_cmp) set_b[0] = 1'b1;
            if (i_WE) begin
                if ((i_address % 4) != 0) set_b[1] = 1'b1;
                if (is_ram(i_address)) begin
                    m_ram[int'(i_address >> 2)]   = i_data;
                    m_known[int'(i_address >> 2)] = 1'b1;
                end else if (is_mmio(i_address)) begin
                    case ((i_address >> 2) & 32'd3)
                        32'd0:   m_gpio = i_data;
                        32'd1:   next_cycle = i_data;
                        32'd2:   m_cmp = i_data;
                        default: clr_b = i_data[2:0];
                    endcase
                end else begin
                    set_b[2] = 1'b1;
                end
            end
            m_cycle  = next_cycle;
            m_status = (m_status & ~clr_b) | set_b;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge i_clk) begin
        if (model_known(i_address)) check("model_o_data", o_data, model_read(i_address));
        check("model_o_gpio", o_gpio, m_gpio);
        check("model_o_irq", {31'd0, o_irq}, {31'd0, m_status[0]});
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d);
        @(posedge i_clk);
        #2;
        i_WE      = we;
        i_address = a;
        i_data    = d;
    endtask

    task automatic chk_data(input string name, input logic [31:0] exp);
        @(negedge i_clk);
        check(name, o_data, exp);
    endtask

    initial begin
        #1;
        check("rst_gpio", o_gpio, 32'd0);
        check("rst_irq", {31'd0, o_irq}, 32'd0);

        // Release reset and watch the counter from 0.
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b1;
        i_address = BASE + 32'h4;
        chk_data("cycle_0", 32'd0);
        for (int k = 0; k < 5; k++) drive(1'b0, BASE + 32'h4, 32'd0);
        chk_data("cycle_5", 32'd5);

        // RAM write/read and read-during-write.
        drive(1'b1, 32'h0, 32'h1111_1111);
        drive(1'b1, 32'h10, 32'hDEAD_BEEF);
        drive(1'b0, 32'h10, 32'd0);
        chk_data("ram_rd", 32'hDEAD_BEEF);
        drive(1'b1, 32'h10, 32'h0000_1234);
        chk_data("ram_rdw_old", 32'hDEAD_BEEF);
        drive(1'b0, 32'h10, 32'd0);
        chk_data("ram_rdw_new", 32'h0000_1234);

        // GPIO.
        drive(1'b1, BASE, 32'hA5A5_0001);
        drive(1'b0, BASE, 32'd0);
        chk_data("gpio_rd", 32'hA5A5_0001);
        check("gpio_out", o_gpio, 32'hA5A5_0001);

        // Counter load and wrap; the FFFF_FFFF cycle matches the reset compare value.
        drive(1'b1, BASE + 32'h4, 32'hFFFF_FFFE);
        drive(1'b0, BASE + 32'h4, 32'd0);
        chk_data("cycle_load", 32'hFFFF_FFFE);
        drive(1'b0, BASE + 32'h4, 32'd0);
        chk_data("cycle_max", 32'hFFFF_FFFF);
        drive(1'b0, BASE + 32'h4, 32'd0);
        chk_data("cycle_wrap", 32'd0);
        check("irq_wrap_hit", {31'd0, o_irq}, 32'd1);

        drive(1'b1, BASE + 32'hC, 32'd7);
        drive(1'b0, BASE + 32'hC, 32'd0);
        chk_data("status_clr_all", 32'd0);

        // Timer: CMP=20 written while counter reads 10.
        drive(1'b1, BASE + 32'h4, 32'd10);
        drive(1'b1, BASE + 32'h8, 32'd20);
        for (int k = 1; k <= 10; k++) drive(1'b0, BASE + 32'h4, 32'd0);
        chk_data("cycle_20", 32'd20);
        check("irq_before_hit", {31'd0, o_irq}, 32'd0);
        drive(1'b0, BASE + 32'hC, 32'd0);
        chk_data("status_hit", 32'd1);
        check("irq_hit", {31'd0, o_irq}, 32'd1);
        drive(1'b1, BASE + 32'hC, 32'd1);
        drive(1'b0, BASE + 32'hC, 32'd0);
        chk_data("status_w1c_timer", 32'd0);
        check("irq_cleared", {31'd0, o_irq}, 32'd0);

        // Clear issued in the match cycle: set wins.
        drive(1'b1, BASE + 32'h4, 32'd100);
        drive(1'b1, BASE + 32'h8, 32'd102);
        drive(1'b0, BASE + 32'h4, 32'd0);
        chk_data("cycle_101", 32'd101);
        drive(1'b1, BASE + 32'hC, 32'd1);
        drive(1'b0, BASE + 32'hC, 32'd0);
        chk_data("clr_vs_hit", 32'd1);
        check("irq_set_wins", {31'd0, o_irq}, 32'd1);

        // Error flags.
        drive(1'b1, BASE + 32'hC, 32'd7);
        drive(1'b1, 32'h0000_1000, 32'h55);
        drive(1'b0, BASE + 32'hC, 32'd0);
        chk_data("unmap_status", 32'd4);
        drive(1'b0, 32'h0000_1000, 32'd0);
        chk_data("unmap_rd", 32'd0);
        drive(1'b0, 32'h0, 32'd0);
        chk_data("ram_not_aliased", 32'h1111_1111);
        drive(1'b1, 32'h13, 32'hCAFE_F00D);
        drive(1'b0, BASE + 32'hC, 32'd0);
        chk_data("misal_status", 32'd6);
        drive(1'b0, 32'h10, 32'd0);
        chk_data("misal_ram", 32'hCAFE_F00D);
        drive(1'b1, BASE + 32'hC, 32'h6);
        drive(1'b0, BASE + 32'hC, 32'd0);
        chk_data("status_w1c_err", 32'd0);
        drive(1'b1, BASE + 32'hD, 32'h2);
        drive(1'b0, BASE + 32'h5, 32'd0);
        drive(1'b0, BASE + 32'hC, 32'd0);
        chk_data("misal_status_set_wins", 32'd2);

        // Asynchronous reset between edges.
        drive(1'b1, BASE, 32'h0000_00FF);
        drive(1'b0, BASE + 32'h4, 32'd0);
        @(negedge i_clk);
        check("gpio_pre_rst", o_gpio, 32'h0000_00FF);
        #1;
        i_reset_n = 1'b0;
        #1;
        check("gpio_async_rst", o_gpio, 32'd0);
        check("cycle_async_rst", o_data, 32'd0);
        check("irq_async_rst", {31'd0, o_irq}, 32'd0);
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b1;
        drive(1'b0, BASE + 32'h8, 32'd0);
        chk_data("cmp_reset", 32'hFFFF_FFFF);
        drive(1'b0, BASE + 32'hC, 32'd0);
        chk_data("status_reset", 32'd0);

        drive(1'b0, 32'h0, 32'd0);
        @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
